// File: rtl/alu_exec_pkg.sv
// Shared processor definitions: ALU operation codes, execute-stage FSM encoding
// and helpers used by alu_control and alu_exec.
package alu_exec_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_COMP   = 5'd1,
    ALU_AND    = 5'd2,
    ALU_XOR    = 5'd3,
    ALU_SLL    = 5'd4,
    ALU_SRL    = 5'd5,
    ALU_SRA    = 5'd6,
    ALU_PASS_B = 5'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LEFT        = 2'd0,
    SH_RIGHT_LOG   = 2'd1,
    SH_RIGHT_ARITH = 2'd2
  } shift_mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              zero;
    logic              sign;
    logic              carry;
  } alu_out_t;

  localparam alu_out_t OUT_RESET = '{value: '0, zero: 1'b1, sign: 1'b0, carry: 1'b0};

  function automatic logic is_shift_op(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic shift_mode_e shift_mode_of(input logic [4:0] code);
    case (code)
      ALU_SRL: return SH_RIGHT_LOG;
      ALU_SRA: return SH_RIGHT_ARITH;
      default: return SH_LEFT;
    endcase
  endfunction

  // Flags are always derived from the final value, so build them in one place.
  function automatic alu_out_t make_out(input logic [DATA_W-1:0] value, input logic carry);
    alu_out_t o;
    o.value = value;
    o.zero  = (value == '0);
    o.sign  = value[DATA_W-1];
    o.carry = carry;
    return o;
  endfunction

endpackage

// File: rtl/alu_exec_shift_unit.sv
// One-bit-per-cycle shifter with its shift-amount down-counter; the shift
// kind is captured at load so later control changes cannot disturb it.
module shift_unit
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  shift_mode_e       mode_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] shifted,
  output logic              last
);

  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] count;
  shift_mode_e        mode;

  always_comb begin
    shifted = acc;
    case (mode)
      SH_LEFT:        shifted = {acc[DATA_W-2:0], 1'b0};
      SH_RIGHT_LOG:   shifted = {1'b0, acc[DATA_W-1:1]};
      SH_RIGHT_ARITH: shifted = {acc[DATA_W-1], acc[DATA_W-1:1]};
      default:        shifted = acc;
    endcase
  end

  assign last = (count == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      count <= '0;
      mode  <= SH_LEFT;
    end else if (load) begin
      acc   <= data_in;
      count <= shamt;
      mode  <= mode_in;
    end else if (step) begin
      acc   <= shifted;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, serial shifts through
// shift_unit, registered result and flags with a one-cycle done pulse.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        alu_control_signal,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              sign,
  output logic              carry,
  output logic              busy,
  output logic              done
);

  alu_state_e         state, state_next;
  alu_out_t           out_reg;
  alu_out_t           single_out;
  logic [DATA_W:0]    sum;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               go_shift;
  logic [DATA_W-1:0]  shifted;
  logic               shift_last;

  assign shamt    = op_b[SHAMT_W-1:0];
  assign accept   = (state == ST_IDLE) && start;
  assign go_shift = accept && is_shift_op(alu_control_signal) && (shamt != '0);

  // Shift codes only reach this path with a zero shift amount, so they pass op_a.
  always_comb begin
    sum        = {1'b0, op_a} + {1'b0, op_b};
    single_out = OUT_RESET;
    case (alu_control_signal)
      ALU_ADD:    single_out = make_out(sum[DATA_W-1:0], sum[DATA_W]);
      ALU_COMP:   single_out = make_out(~op_b + DATA_W'(1), 1'b0);
      ALU_AND:    single_out = make_out(op_a & op_b, 1'b0);
      ALU_XOR:    single_out = make_out(op_a ^ op_b, 1'b0);
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:    single_out = make_out(op_a, 1'b0);
      ALU_PASS_B: single_out = make_out(op_b, 1'b0);
      default:    single_out = make_out('0, 1'b0);
    endcase
  end

  shift_unit u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (go_shift),
    .step    (state == ST_SHIFT),
    .mode_in (shift_mode_of(alu_control_signal)),
    .shamt   (shamt),
    .data_in (op_a),
    .shifted (shifted),
    .last    (shift_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (go_shift) begin
          state_next = ST_SHIFT;
        end else if (accept) begin
          state_next = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (shift_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg <= OUT_RESET;
    end else if (accept && !go_shift) begin
      out_reg <= single_out;
    end else if ((state == ST_SHIFT) && shift_last) begin
      out_reg <= make_out(shifted, 1'b0);
    end
  end

  assign result = out_reg.value;
  assign zero   = out_reg.zero;
  assign sign   = out_reg.sign;
  assign carry  = out_reg.carry;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors for every op, shift
// latencies, start masking while busy, and reset abort of a running shift.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ctl = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        zero, sign, carry, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .alu_control_signal (ctl),
    .op_a               (a),
    .op_b               (b),
    .result             (result),
    .zero               (zero),
    .sign               (sign),
    .carry              (carry),
    .busy               (busy),
    .done               (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_op(input string tag, input logic [4:0] code, input logic [31:0] va,
                        input logic [31:0] vb, input int exp_lat, input logic [31:0] exp_res,
                        input logic ez, input logic es, input logic ec);
    int lat;
    int busy_cycles;
    ctl = code; a = va; b = vb; start = 1'b1;
    lat = 0; busy_cycles = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      if (lat == 0) begin
        a = ~va; b = ~vb; ctl = 5'd0;
      end
      lat++;
      if (busy) busy_cycles++;
    end while (!done && lat < 40);
    $display("%s: code=%0d a=%h b=%h -> result=%h z=%b s=%b c=%b latency=%0d",
             tag, code, va, vb, result, zero, sign, carry, lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cycles, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, zero, ez);
    check({tag, " sign"}, sign, es);
    check({tag, " carry"}, carry, ec);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    logic seen_done;

    repeat (2) @(negedge clk);
    $display("reset: result=%h z=%b s=%b c=%b busy=%b done=%b", result, zero, sign, carry, busy, done);
    check("reset result", result, 32'd0);
    check("reset zero", zero, 1'b1);
    check("reset sign", sign, 1'b0);
    check("reset carry", carry, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    run_op("add_wrap",  ALU_ADD,    32'hFFFFFFFF, 32'h00000001, 1,  32'h00000000, 1, 0, 1);
    run_op("sra_neg",   ALU_SRA,    32'h80000010, 32'h00000004, 5,  32'hF8000001, 0, 1, 0);
    run_op("sll_zero",  ALU_SLL,    32'h00000001, 32'h00000000, 1,  32'h00000001, 0, 0, 0);
    run_op("sll_max",   ALU_SLL,    32'h00000001, 32'h0000001F, 32, 32'h80000000, 0, 1, 0);
    run_op("srl_max",   ALU_SRL,    32'h80000000, 32'h0000001F, 32, 32'h00000001, 0, 0, 0);
    run_op("sra_pos",   ALU_SRA,    32'h7FFFFFFF, 32'h00000003, 4,  32'h0FFFFFFF, 0, 0, 0);
    run_op("comp_min",  ALU_COMP,   32'h12345678, 32'h80000000, 1,  32'h80000000, 0, 1, 0);
    run_op("and",       ALU_AND,    32'hF0F0F0F0, 32'hFF00FF00, 1,  32'hF000F000, 0, 1, 0);
    run_op("xor",       ALU_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 1,  32'hF0F00F0F, 0, 1, 0);
    run_op("pass_b",    ALU_PASS_B, 32'hDEADBEEF, 32'h12345678, 1,  32'h12345678, 0, 0, 0);
    run_op("add_small", ALU_ADD,    32'h00000007, 32'h00000009, 1,  32'h00000010, 0, 0, 0);
    run_op("add_msb",   ALU_ADD,    32'h80000000, 32'h80000000, 1,  32'h00000000, 1, 0, 1);
    run_op("add_nocar", ALU_ADD,    32'h00000003, 32'h00000004, 1,  32'h00000007, 0, 0, 0);
    run_op("illegal",   5'd20,      32'h00000007, 32'h00000009, 1,  32'h00000000, 1, 0, 0);

    // SRL by 8 with an ADD start pulsed and op_a changed while shifting.
    ctl = ALU_SRL; a = 32'h000000F0; b = 32'd8; start = 1'b1;
    lat = 0;
    @(negedge clk); lat++; start = 1'b0;
    @(negedge clk); lat++; ctl = ALU_ADD; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk); lat++; start = 1'b0; a = 32'h0000FFFF;
    while (!done && lat < 40) begin
      @(negedge clk); lat++;
    end
    $display("srl_ignore: result=%h z=%b latency=%0d", result, zero, lat);
    check("srl_ignore latency", lat, 9);
    check("srl_ignore result", result, 32'd0);
    check("srl_ignore zero", zero, 1'b1);
    ctl = ALU_ADD; a = 32'd2; b = 32'd3; start = 1'b1;
    @(negedge clk);
    check("start_in_done ignored", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    $display("add_after_done: result=%h done=%b", result, done);
    check("add_after_done done", done, 1'b1);
    check("add_after_done result", result, 32'd5);
    @(negedge clk);

    // Reset during the third cycle of a 10-cycle shift.
    ctl = ALU_SLL; a = 32'd3; b = 32'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    $display("mid_reset: result=%h z=%b s=%b c=%b busy=%b done=%b", result, zero, sign, carry, busy, done);
    check("mid_reset result", result, 32'd0);
    check("mid_reset zero", zero, 1'b1);
    check("mid_reset sign", sign, 1'b0);
    check("mid_reset carry", carry, 1'b0);
    check("mid_reset busy", busy, 1'b0);
    check("mid_reset done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("no_done_after_reset", seen_done, 1'b0);
    check("post_reset result", result, 32'd0);

    run_op("comp5", ALU_COMP, 32'h00000000, 32'h00000005, 1, 32'hFFFFFFFB, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port start  in  1  request pulse; sampled only in IDLE.
REQ-004 SHALL have port alu_control_signal  in  5  operation code from alu_control.
REQ-005 SHALL have port op_a  in  32  first operand (rs, or the shifted value).
REQ-006 SHALL have port op_b  in  32  second operand (rt/immediate); op_b[4:0] is the shift amount.
REQ-007 SHALL have port result  out  32  registered result; held until the next accepted start.
REQ-008 SHALL have ports zero, sign, carry  out  1 each  registered flags for result.
REQ-009 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse; result and flags valid in that cycle.

Function
REQ-011 SHALL decode these codes: 0 ADD (a+b), 1 COMP (~b+1), 2 AND, 3 XOR, 4 SLL (a<<shamt), 5 SRL (logical), 6 SRA (arithmetic), 7 PASS_B (b).
REQ-012 SHALL treat codes 8-31 as illegal: result 0, zero 1, sign 0, carry 0; completion as a single-cycle operation.
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL latch op_a, op_b and alu_control_signal on the edge where start=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-015 IDLE->DONE for non-shift codes, and for shift codes with shamt=0; result is written on that same edge.
REQ-016 IDLE->SHIFT for shift codes with shamt!=0: accumulator loaded with op_a, counter loaded with shamt.
REQ-017 In SHIFT, each cycle SHALL shift the accumulator by exactly one bit and decrement the counter; on the edge where the counter equals 1, the final value SHALL be written to result and the FSM SHALL go to DONE.
REQ-018 DONE SHALL last exactly one cycle, assert done, then return to IDLE.
REQ-019 Latency from start edge to done: 1 cycle for single-cycle operations; shamt+1 cycles for shifts (max 32).
REQ-020 start SHALL be ignored in SHIFT and DONE; a start in the cycle after done (IDLE) SHALL be accepted.
REQ-021 carry SHALL equal bit 32 of the 33-bit ADD sum, and 0 for all other codes.
REQ-022 zero SHALL equal (result==0); sign SHALL equal result[31]; both are computed on the final value.
REQ-023 SRA SHALL replicate op_a[31] into every vacated bit; SRL and SLL SHALL fill with 0.
REQ-024 COMP of 0x80000000 SHALL yield 0x80000000 (wrap-around, no trap).

Reset
REQ-025 While rst=0: state IDLE, result 0, zero 1, sign 0, carry 0, busy 0, done 0, counter and accumulator 0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow reset release.

Structure
REQ-027 The alu_control_signal code constants and the FSM state encoding SHALL reside in the shared processor package also used by alu_control.
REQ-028 The single-bit shifter plus its down-counter SHALL be one sub-module, shift_unit; all other logic is inline.

Verification
REQ-029 ADD a=0xFFFFFFFF, b=1, start -> done after 1 cycle; result 0, zero 1, carry 1, sign 0.
REQ-030 SRA a=0x80000010, b=4 -> busy for 5 cycles, done on 5th cycle after start; result 0xF8000001, sign 1.
REQ-031 SLL a=1, b=0 -> done after 1 cycle, result 1; SLL a=1, b=31 -> done after 32 cycles, result 0x80000000.
REQ-032 Start SRL a=0xF0, b=8, then pulse start with ADD and change op_a during SHIFT -> ignored; result 0, zero 1; ADD accepted in the cycle after done.
REQ-033 rst low during SHIFT (cycle 3 of 10), release -> outputs at reset values, no done pulse; new COMP b=5 -> result 0xFFFFFFFB.
REQ-034 Code 5'd20, a=7, b=9 -> done after 1 cycle; result 0, zero 1.
